// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch stage: word width, canonical NOP
// and the fetch FSM state encoding.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
    localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, issues one outstanding imem request at a
// time, and buffers the returned word until decode consumes it.
module if_fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [XLEN-1:0] pc4_q, pc4_d;

    logic [XLEN-1:0] pc_plus4;
    logic            consume;

    assign pc_plus4 = pc_q + PC_STEP;
    assign consume  = valid_q & ~stall;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        kill_d   = kill_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        pc4_d    = pc4_q;

        if (redirect) begin
            pc_d    = word_align(redirect_pc);
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            unique case (state_q)
                REQ: begin
                    // A grant on the redirect edge accepts the stale address;
                    // its response must be dropped later.
                    if (imem_gnt) begin
                        state_d = WAIT;
                        kill_d  = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_d = REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                HOLD:    state_d = REQ;
                default: state_d = REQ;
            endcase
        end else begin
            unique case (state_q)
                REQ: begin
                    if (imem_gnt) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            instr_d  = imem_rdata;
                            pc_out_d = pc_q;
                            pc4_d    = pc_plus4;
                            valid_d  = 1'b1;
                            pc_d     = pc_plus4;
                            state_d  = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (consume) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            kill_q   <= 1'b0;
            valid_q  <= 1'b0;
            instr_q  <= NOP_INSTR;
            pc_out_q <= '0;
            pc4_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            kill_q   <= kill_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            pc4_q    <= pc4_d;
        end
    end

    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;
    assign valid_out = valid_q;
    assign instr_out = instr_q;
    assign pc_out    = pc_out_q;
    assign pc4_out   = pc4_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; a second instance with a top-of-memory
// reset PC exercises address wrap.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        req_a, valid_a;
    logic [31:0] addr_a, instr_a, pc_a, pc4_a;
    logic        req_b, valid_b;
    logic [31:0] addr_b, instr_b, pc_b, pc4_b;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(req_a), .imem_addr(addr_a),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .valid_out(valid_a), .instr_out(instr_a), .pc_out(pc_a), .pc4_out(pc4_a)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(req_b), .imem_addr(addr_b),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .valid_out(valid_b), .instr_out(instr_b), .pc_out(pc_b), .pc4_out(pc4_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick(); tick();
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", valid_a); end
        n_checks++; if (instr_a !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h want %h", instr_a, NOP); end
        n_checks++; if (pc_a !== 32'h0) begin n_fail++; $display("FAIL rst_pc_out: got %h want 0", pc_a); end
        n_checks++; if (pc4_a !== 32'h0) begin n_fail++; $display("FAIL rst_pc4_out: got %h want 0", pc4_a); end
        reset = 1'b0;
        n_checks++; if (req_a !== 1'b1) begin n_fail++; $display("FAIL rst_req: got %0b want 1", req_a); end
        n_checks++; if (addr_a !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", addr_a); end
        n_checks++; if (addr_b !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rst_addr_wrapinst: got %h want fffffffc", addr_b); end
    endtask

    task automatic test_fetch();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; stall = 1'b1;
        n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL fetch_req_wait: got %0b want 0", req_a); end
        tick();
        imem_rvalid = 1'b0;
        n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL fetch_valid: got %0b want 1", valid_a); end
        n_checks++; if (instr_a !== 32'h0050_0093) begin n_fail++; $display("FAIL fetch_instr: got %h want 00500093", instr_a); end
        n_checks++; if (pc_a !== 32'h0) begin n_fail++; $display("FAIL fetch_pc: got %h want 0", pc_a); end
        n_checks++; if (pc4_a !== 32'h4) begin n_fail++; $display("FAIL fetch_pc4: got %h want 4", pc4_a); end
        n_checks++; if (addr_a !== 32'h4) begin n_fail++; $display("FAIL fetch_next_addr: got %h want 4", addr_a); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (valid_a !== 1'b1 || instr_a !== 32'h0050_0093 || pc4_a !== 32'h4)
                begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%0b i=%h p4=%h want 1/00500093/4", i, valid_a, instr_a, pc4_a); end
            n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %0b want 0", i, req_a); end
        end
        stall = 1'b0;
        tick();
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL consume_valid: got %0b want 0", valid_a); end
        n_checks++; if (instr_a !== NOP) begin n_fail++; $display("FAIL consume_instr: got %h want nop", instr_a); end
        n_checks++; if (req_a !== 1'b1 || addr_a !== 32'h4) begin n_fail++; $display("FAIL consume_req: got %0b@%h want 1@4", req_a, addr_a); end
    endtask

    task automatic test_redirect_wait();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        n_checks++; if (req_a !== 1'b0 || addr_a !== 32'h100) begin n_fail++; $display("FAIL rdw_wait: got req=%0b addr=%h want 0/100", req_a, addr_a); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        n_checks++; if (valid_a !== 1'b0 || instr_a !== NOP) begin n_fail++; $display("FAIL rdw_drop: got v=%0b i=%h want 0/nop", valid_a, instr_a); end
        n_checks++; if (req_a !== 1'b1 || addr_a !== 32'h100) begin n_fail++; $display("FAIL rdw_refetch: got %0b@%h want 1@100", req_a, addr_a); end
    endtask

    task automatic test_redirect_same_cycle();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        redirect = 1'b1; redirect_pc = 32'h180;
        tick();
        n_checks++; if (valid_a !== 1'b0 || req_a !== 1'b1 || addr_a !== 32'h180)
            begin n_fail++; $display("FAIL rsc_rvalid: got v=%0b req=%0b addr=%h want 0/1/180", valid_a, req_a, addr_a); end
        imem_rvalid = 1'b0; imem_gnt = 1'b1; redirect_pc = 32'h200;
        tick();
        imem_gnt = 1'b0; redirect = 1'b0;
        n_checks++; if (req_a !== 1'b0 || addr_a !== 32'h200) begin n_fail++; $display("FAIL rsc_gnt: got req=%0b addr=%h want 0/200", req_a, addr_a); end
        imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
        tick();
        imem_rvalid = 1'b0;
        n_checks++; if (valid_a !== 1'b0 || req_a !== 1'b1 || addr_a !== 32'h200)
            begin n_fail++; $display("FAIL rsc_killed: got v=%0b req=%0b addr=%h want 0/1/200", valid_a, req_a, addr_a); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333; stall = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        n_checks++; if (valid_a !== 1'b1 || instr_a !== 32'h3333_3333 || pc_a !== 32'h200 || pc4_a !== 32'h204)
            begin n_fail++; $display("FAIL rsc_fetch: got v=%0b i=%h pc=%h p4=%h want 1/33333333/200/204", valid_a, instr_a, pc_a, pc4_a); end
        stall = 1'b0;
        tick();
        n_checks++; if (req_a !== 1'b1 || addr_a !== 32'h204) begin n_fail++; $display("FAIL rsc_next: got %0b@%h want 1@204", req_a, addr_a); end
    endtask

    task automatic test_gnt_withheld();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (req_a !== 1'b1 || addr_a !== 32'h204 || valid_a !== 1'b0)
                begin n_fail++; $display("FAIL nognt[%0d]: got req=%0b addr=%h v=%0b want 1/204/0", i, req_a, addr_a, valid_a); end
        end
        imem_rvalid = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        n_checks++; if (req_a !== 1'b1 || addr_a !== 32'h100) begin n_fail++; $display("FAIL nognt_redir: got %0b@%h want 1@100", req_a, addr_a); end
    endtask

    task automatic test_back_to_back();
        // gnt held high throughout: ignored outside REQ, so one fetch per 3 cycles.
        imem_gnt = 1'b1; stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            imem_rvalid = 1'b1; imem_rdata = 32'hA000_0000 + i;
            tick();
            imem_rvalid = 1'b0;
            n_checks++; if (valid_a !== 1'b1 || instr_a !== (32'hA000_0000 + i) || pc_a !== (32'h100 + 4 * i))
                begin n_fail++; $display("FAIL b2b[%0d]: got v=%0b i=%h pc=%h", i, valid_a, instr_a, pc_a); end
            tick();
            n_checks++; if (req_a !== 1'b1 || valid_a !== 1'b0 || addr_a !== (32'h104 + 4 * i))
                begin n_fail++; $display("FAIL b2b_req[%0d]: got req=%0b v=%0b addr=%h", i, req_a, valid_a, addr_a); end
        end
        imem_gnt = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0; imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
        tick();
        imem_rvalid = 1'b0;
        n_checks++; if (valid_b !== 1'b1 || pc_b !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got v=%0b pc=%h want 1/fffffffc", valid_b, pc_b); end
        n_checks++; if (pc4_b !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h want 0", pc4_b); end
        n_checks++; if (addr_b !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h want 0", addr_b); end
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; reset = 1'b1; imem_rvalid = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        reset = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0;
        n_checks++; if (valid_a !== 1'b0 || instr_a !== NOP || pc_a !== 32'h0 || pc4_a !== 32'h0)
            begin n_fail++; $display("FAIL midrst_out: got v=%0b i=%h pc=%h p4=%h want 0/nop/0/0", valid_a, instr_a, pc_a, pc4_a); end
        n_checks++; if (req_a !== 1'b1 || addr_a !== 32'h0) begin n_fail++; $display("FAIL midrst_req: got %0b@%h want 1@0", req_a, addr_a); end
        n_checks++; if (pc_b !== 32'h0 || pc4_b !== 32'h0 || addr_b !== 32'hFFFF_FFFC)
            begin n_fail++; $display("FAIL midrst_wrapinst: got pc=%h p4=%h addr=%h want 0/0/fffffffc", pc_b, pc4_b, addr_b); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_gnt_withheld();
        test_back_to_back();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
